// File: rtl/vga_timing_gen_if.sv
// Bundle of the VGA timing generator's game-logic and DAC-side signals.
// master: the timing generator. slave: the consumer (game logic / DAC pins).
interface vga_timing_gen_if;
  logic [23:0] color_data;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        pixel_clk;
  logic        frame_clk;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_BLANK_N;
  logic        VGA_SYNC_N;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;

  modport master (
    input  color_data,
    output DrawX, DrawY, pixel_clk, frame_clk,
    output VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
    output VGA_R, VGA_G, VGA_B
  );

  modport slave (
    output color_data,
    input  DrawX, DrawY, pixel_clk, frame_clk,
    input  VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
    input  VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a registered pixel output stage.
// DrawX/DrawY come straight from the counters; every DAC pin is registered
// from the pre-increment counters, so pins lag DrawX/DrawY by one pixel.
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic             Clk,
  input  logic             Reset,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  // Compare in 11 bits so the parameter sums never truncate.
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [10:0] H_VIS_W  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_W  = 11'(V_VISIBLE);

  logic [DIV_W-1:0] div;
  logic [9:0]       hc;
  logic [9:0]       vc;
  logic             pixel_en;
  logic [10:0]      hc_w;
  logic [10:0]      vc_w;
  logic             hs_active;
  logic             vs_active;
  logic             visible;

  logic             hs_q;
  logic             vs_q;
  logic             frame_q;
  logic             blank_n_q;
  logic [7:0]       r_q;
  logic [7:0]       g_q;
  logic [7:0]       b_q;

  assign pixel_en  = (div == DIV_LAST);
  assign hc_w      = {1'b0, hc};
  assign vc_w      = {1'b0, vc};
  assign hs_active = (hc_w >= HS_START) && (hc_w < HS_END);
  assign vs_active = (vc_w >= VS_START) && (vc_w < VS_END);
  assign visible   = (hc_w < H_VIS_W) && (vc_w < V_VIS_W);

  // Clock divider producing the one-Clk-wide pixel enable.
  always_ff @(posedge Clk) begin
    if (Reset)         div <= '0;
    else if (pixel_en) div <= '0;
    else               div <= div + DIV_ONE;
  end

  // Horizontal/vertical scan counters, advanced once per pixel.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hc <= '0;
      vc <= '0;
    end else if (pixel_en) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  // Pin stage: sync, blank and colour registered from the current (pre-increment) position.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      frame_q   <= 1'b1;
      blank_n_q <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else if (pixel_en) begin
      hs_q      <= !hs_active;
      vs_q      <= !vs_active;
      frame_q   <= !vs_active;
      blank_n_q <= visible;
      r_q       <= visible ? vga.color_data[23:16] : 8'd0;
      g_q       <= visible ? vga.color_data[15:8]  : 8'd0;
      b_q       <= visible ? vga.color_data[7:0]   : 8'd0;
    end
  end

  assign vga.DrawX       = hc;
  assign vga.DrawY       = vc;
  assign vga.pixel_clk   = pixel_en;
  assign vga.frame_clk   = frame_q;
  assign vga.VGA_HS      = hs_q;
  assign vga.VGA_VS      = vs_q;
  assign vga.VGA_BLANK_N = blank_n_q;
  assign vga.VGA_SYNC_N  = 1'b0;
  assign vga.VGA_R       = r_q;
  assign vga.VGA_G       = g_q;
  assign vga.VGA_B       = b_q;
endmodule
